// File: rtl/song_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : song_seq                                                        |
// | Desc   : ROM-driven multi-voice note sequencer (chords, hold, loop)      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+

module song_seq #(
   parameter  int NUM_SONGS  = 4,
   parameter  int DEPTH_LOG2 = 5,
   parameter  int NOTE_W     = 6,
   parameter  int DUR_W      = 6,
   parameter  int META_W     = 3,
   parameter  int NUM_VOICES = 3,
   localparam int SONG_W     = $clog2(NUM_SONGS),
   localparam int EW         = 1 + NOTE_W + DUR_W + META_W,
   localparam int AW         = SONG_W + DEPTH_LOG2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         play,
   input  logic [SONG_W-1:0]            song_sel,
   input  logic                         loop,
   input  logic                         beat,
   output logic [AW-1:0]                rom_addr,
   input  logic [EW-1:0]                rom_data,
   output logic [NUM_VOICES-1:0]        load_out,
   output logic [NUM_VOICES*NOTE_W-1:0] note_out,
   output logic [NUM_VOICES*DUR_W-1:0]  dur_out,
   output logic                         playing,
   output logic                         song_done,
   output logic                         overflow
);
   localparam int                    VP_W     = $clog2(NUM_VOICES + 1);
   localparam logic [VP_W-1:0]       VP_SAT   = VP_W'(NUM_VOICES);
   localparam logic [VP_W-1:0]       VP_ONE   = VP_W'(1);
   localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
   localparam logic [DUR_W-1:0]      DUR_ONE  = DUR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_HOLD   = 3'd3,
      S_END    = 3'd4
   } state_t;

   state_t                r_state, w_state, w_adv_state;
   logic [SONG_W-1:0]     r_song, w_song;
   logic [DEPTH_LOG2-1:0] r_idx, w_idx, w_adv_idx;
   logic [VP_W-1:0]       r_vp, w_vp;
   logic [DUR_W-1:0]      r_beats_left, w_beats_left;
   logic [NUM_VOICES-1:0] r_load, w_load;
   logic [NOTE_W-1:0]     r_note [NUM_VOICES];
   logic [NOTE_W-1:0]     w_note [NUM_VOICES];
   logic [DUR_W-1:0]      r_dur  [NUM_VOICES];
   logic [DUR_W-1:0]      w_dur  [NUM_VOICES];
   logic                  r_overflow, w_overflow;

   logic                  w_e_adv, w_term, w_change;
   logic [NOTE_W-1:0]     w_e_note;
   logic [DUR_W-1:0]      w_e_dur;
   logic [META_W-1:0]     w_meta_unused;

   assign w_e_adv       = rom_data[EW-1];
   assign w_e_note      = rom_data[EW-2 -: NOTE_W];
   assign w_e_dur       = rom_data[META_W +: DUR_W];
   assign w_meta_unused = rom_data[META_W-1:0];
   assign w_term        = w_e_adv && (w_e_note == '0) && (w_e_dur == '0);
   assign w_change      = (song_sel != r_song);

   // The last entry of a song ends it instead of spilling into the next song.
   assign w_adv_state   = (r_idx == IDX_LAST) ? S_END : S_FETCH;
   assign w_adv_idx     = (r_idx == IDX_LAST) ? r_idx : r_idx + IDX_ONE;

   always_comb begin
      w_state      = r_state;
      w_song       = r_song;
      w_idx        = r_idx;
      w_vp         = r_vp;
      w_beats_left = r_beats_left;
      w_load       = '0;
      w_note       = r_note;
      w_dur        = r_dur;
      w_overflow   = r_overflow;

      if (r_state == S_IDLE) begin
         if (play) begin
            w_song  = song_sel;
            w_idx   = '0;
            w_vp    = '0;
            w_state = S_FETCH;
         end
      end else if (r_state == S_END) begin
         if (loop) begin
            w_idx   = '0;
            w_vp    = '0;
            w_state = S_FETCH;
         end else begin
            w_state = S_IDLE;
         end
      end else if (!play) begin
         w_state = r_state;
      end else if (w_change) begin
         w_song  = song_sel;
         w_idx   = '0;
         w_vp    = '0;
         w_state = S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: w_state = S_DECODE;
            S_DECODE: begin
               if (w_term) begin
                  w_state = S_END;
               end else begin
                  if (w_e_note != '0) begin
                     if (r_vp < VP_SAT) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                           if (r_vp == VP_W'(v)) begin
                              w_load[v] = 1'b1;
                              w_note[v] = w_e_note;
                              w_dur[v]  = w_e_dur;
                           end
                        end
                     end else begin
                        w_overflow = 1'b1;
                     end
                  end
                  if (!w_e_adv) begin
                     w_vp    = (r_vp < VP_SAT) ? r_vp + VP_ONE : VP_SAT;
                     w_idx   = w_adv_idx;
                     w_state = w_adv_state;
                  end else begin
                     w_vp = '0;
                     if (w_e_dur == '0) begin
                        w_idx   = w_adv_idx;
                        w_state = w_adv_state;
                     end else begin
                        w_beats_left = w_e_dur;
                        w_state      = S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (beat) begin
                  w_beats_left = r_beats_left - DUR_ONE;
                  if (r_beats_left == DUR_ONE) begin
                     w_idx   = w_adv_idx;
                     w_state = w_adv_state;
                  end
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_song       <= '0;
         r_idx        <= '0;
         r_vp         <= '0;
         r_beats_left <= '0;
         r_load       <= '0;
         r_overflow   <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_note[v] <= '0;
            r_dur[v]  <= '0;
         end
      end else begin
         r_state      <= w_state;
         r_song       <= w_song;
         r_idx        <= w_idx;
         r_vp         <= w_vp;
         r_beats_left <= w_beats_left;
         r_load       <= w_load;
         r_overflow   <= w_overflow;
         r_note       <= w_note;
         r_dur        <= w_dur;
      end
   end

   assign rom_addr  = {r_song, r_idx};
   assign load_out  = r_load;
   assign playing   = (r_state != S_IDLE);
   assign song_done = (r_state == S_END);
   assign overflow  = r_overflow;

   for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
      assign note_out[gv*NOTE_W +: NOTE_W] = r_note[gv];
      assign dur_out[gv*DUR_W +: DUR_W]    = r_dur[gv];
   end

endmodule

`default_nettype wire
